// File: rtl/iter_muldiv_unit.sv
// Iterative RV64 multiply/divide unit: shift-add multiply and restoring divide,
// BITS_PER_CYCLE result bits per clock behind valid/ready handshakes.
module iter_muldiv_unit #(
   parameter int unsigned WIDTH          = 64,
   parameter int unsigned BITS_PER_CYCLE = 1,
   parameter int unsigned OPW            = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OPW-1:0]   op,
   input  logic [WIDTH-1:0] operand1,
   input  logic [WIDTH-1:0] operand2,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy
);

   localparam int unsigned Steps = WIDTH / BITS_PER_CYCLE;
   localparam int unsigned CntW  = $clog2(Steps + 1);

   localparam logic [OPW-1:0] OpMul    = OPW'(3);
   localparam logic [OPW-1:0] OpMulh   = OPW'(18);
   localparam logic [OPW-1:0] OpMulhu  = OPW'(19);
   localparam logic [OPW-1:0] OpMulhsu = OPW'(20);
   localparam logic [OPW-1:0] OpDiv    = OPW'(10);
   localparam logic [OPW-1:0] OpDivu   = OPW'(13);
   localparam logic [OPW-1:0] OpRem    = OPW'(15);
   localparam logic [OPW-1:0] OpRemu   = OPW'(17);

   localparam logic [WIDTH-1:0] MinInt = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StRun, StFin, StDone} state_e;

   state_e             state_q, state_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic               mul_q, mul_d;
   logic               hi_q, hi_d;
   logic               neg_q, neg_d;
   logic               fast_q, fast_d;
   logic [WIDTH-1:0]   result_q, result_d;

   // Request decode
   logic is_mul, is_div, want_hi, sgn1, sgn2;
   always_comb begin
      is_mul  = 1'b0;
      is_div  = 1'b0;
      want_hi = 1'b0;
      sgn1    = 1'b0;
      sgn2    = 1'b0;
      case (op)
         OpMul:    is_mul = 1'b1;
         OpMulh:   begin is_mul = 1'b1; want_hi = 1'b1; sgn1 = 1'b1; sgn2 = 1'b1; end
         OpMulhu:  begin is_mul = 1'b1; want_hi = 1'b1; end
         OpMulhsu: begin is_mul = 1'b1; want_hi = 1'b1; sgn1 = 1'b1; end
         OpDiv:    begin is_div = 1'b1; sgn1 = 1'b1; sgn2 = 1'b1; end
         OpDivu:   is_div = 1'b1;
         OpRem:    begin is_div = 1'b1; want_hi = 1'b1; sgn1 = 1'b1; sgn2 = 1'b1; end
         OpRemu:   begin is_div = 1'b1; want_hi = 1'b1; end
         default:  ;
      endcase
   end

   logic             neg1, neg2, div_zero, ovf, known, fast;
   logic [WIDTH-1:0] mag1, mag2, fast_val;
   always_comb begin
      neg1     = sgn1 && operand1[WIDTH-1];
      neg2     = sgn2 && operand2[WIDTH-1];
      mag1     = neg1 ? -operand1 : operand1;
      mag2     = neg2 ? -operand2 : operand2;
      known    = is_mul || is_div;
      div_zero = is_div && (operand2 == '0);
      ovf      = is_div && sgn1 && (operand1 == MinInt) && (operand2 == '1);
      fast     = !known || div_zero || ovf;
      if (!known)        fast_val = '0;
      else if (div_zero) fast_val = want_hi ? operand1 : '1;
      else               fast_val = want_hi ? '0 : MinInt;
   end

   // One iteration cycle: BITS_PER_CYCLE unrolled shift-add or restoring-subtract steps
   logic [2*WIDTH-1:0] acc_step;
   logic [WIDTH:0]     sum, trial;
   logic               ge;
   always_comb begin
      acc_step = acc_q;
      sum      = '0;
      trial    = '0;
      ge       = 1'b0;
      for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
         if (mul_q) begin
            sum      = {1'b0, acc_step[2*WIDTH-1:WIDTH]} + (acc_step[0] ? {1'b0, mcand_q} : '0);
            acc_step = {sum, acc_step[WIDTH-1:1]};
         end else begin
            trial = {acc_step[2*WIDTH-1:WIDTH], acc_step[WIDTH-1]};
            ge    = trial >= {1'b0, mcand_q};
            if (ge) trial = trial - {1'b0, mcand_q};
            acc_step = {trial[WIDTH-1:0], acc_step[WIDTH-2:0], ge};
         end
      end
   end

   // Sign fix-up; the product is negated as a whole before picking a half
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   half, fin_res;
   always_comb begin
      prod = neg_q ? -acc_q : acc_q;
      half = hi_q ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
      if (fast_q)     fin_res = acc_q[WIDTH-1:0];
      else if (mul_q) fin_res = hi_q ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
      else            fin_res = neg_q ? -half : half;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mul_d    = mul_q;
      hi_d     = hi_q;
      neg_d    = neg_q;
      fast_d   = fast_q;
      result_d = result_q;
      case (state_q)
         StIdle: begin
            if (in_valid && in_ready) begin
               cnt_d   = CntW'(Steps);
               mul_d   = is_mul;
               hi_d    = want_hi;
               neg_d   = is_div && want_hi ? neg1 : (neg1 ^ neg2);
               fast_d  = fast;
               mcand_d = is_mul ? mag1 : mag2;
               if (fast)        acc_d = {{WIDTH{1'b0}}, fast_val};
               else if (is_mul) acc_d = {{WIDTH{1'b0}}, mag2};
               else             acc_d = {{WIDTH{1'b0}}, mag1};
               state_d = fast ? StFin : StRun;
            end
         end
         StRun: begin
            acc_d = acc_step;
            if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
            if (cnt_q <= CntW'(1)) state_d = StFin;
         end
         StFin: begin
            result_d = fin_res;
            state_d  = StDone;
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (flush) state_d = StIdle;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mul_q    <= 1'b0;
         hi_q     <= 1'b0;
         neg_q    <= 1'b0;
         fast_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mul_q    <= mul_d;
         hi_q     <= hi_d;
         neg_q    <= neg_d;
         fast_q   <= fast_d;
         result_q <= result_d;
      end
   end

   assign in_ready  = (state_q == StIdle) && !flush;
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign result    = result_q;

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Scoreboard bench for iter_muldiv_unit: one instance at 1 bit/cycle, one at 4 bits/cycle.
module tb_iter_muldiv_unit;

   logic        clk, rst, in_valid, flush, out_ready;
   logic        in_ready, out_valid, busy;
   logic [5:0]  op;
   logic [63:0] operand1, operand2, result;

   logic        rst4, in_valid4, flush4, out_ready4;
   logic        in_ready4, out_valid4, busy4;
   logic [5:0]  op4;
   logic [63:0] a4, b4, result4;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] exp_q [$];
   logic [5:0]  ops [8] = '{6'd3, 6'd18, 6'd19, 6'd20, 6'd10, 6'd13, 6'd15, 6'd17};

   localparam logic [63:0] MinInt = 64'h8000_0000_0000_0000;

   iter_muldiv_unit #(.WIDTH(64), .BITS_PER_CYCLE(1), .OPW(6)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .operand1(operand1), .operand2(operand2), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .busy(busy)
   );

   iter_muldiv_unit #(.WIDTH(64), .BITS_PER_CYCLE(4), .OPW(6)) u_dut4 (
      .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_ready(in_ready4), .op(op4),
      .operand1(a4), .operand2(b4), .flush(flush4), .out_valid(out_valid4),
      .out_ready(out_ready4), .result(result4), .busy(busy4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout required finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", tag, act, exp);
      end
   endtask

   function automatic logic [63:0] ref_result(input logic [5:0] o, input logic [63:0] a,
                                              input logic [63:0] b);
      logic [127:0]       p;
      logic signed [63:0] sa, sb;
      sa = a;
      sb = b;
      case (o)
         6'd3:  begin p = {64'b0, a} * {64'b0, b}; return p[63:0]; end
         6'd18: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
         6'd19: begin p = {64'b0, a} * {64'b0, b}; return p[127:64]; end
         6'd20: begin p = {{64{a[63]}}, a} * {64'b0, b}; return p[127:64]; end
         6'd10: begin
            if (b == '0) return '1;
            if (a == MinInt && b == '1) return MinInt;
            return sa / sb;
         end
         6'd13: return (b == '0) ? '1 : a / b;
         6'd15: begin
            if (b == '0) return a;
            if (a == MinInt && b == '1) return '0;
            return sa % sb;
         end
         6'd17: return (b == '0) ? a : a % b;
         default: return '0;
      endcase
   endfunction

   task automatic run_op(input string tag, input logic [5:0] o, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input int lat,
                         input int hold);
      int          n;
      logic [63:0] e;
      @(negedge clk);
      check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      op       = o;
      operand1 = a;
      operand2 = b;
      in_valid = 1'b1;
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op       = 6'($urandom);
      operand1 = {$urandom, $urandom};
      operand2 = {$urandom, $urandom};
      n = 0;
      while (!out_valid && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_eq({tag, "_lat"}, 64'(n), 64'(lat));
      e = exp_q.pop_front();
      check_eq({tag, "_res"}, result, e);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_eq({tag, "_hold_res"}, result, e);
         check_eq({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
         check_eq({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check_eq({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      int          n;
      logic        seen;
      logic [5:0]  o;
      logic [63:0] a, b;
      logic        fast;

      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      op = '0; operand1 = '0; operand2 = '0;
      rst4 = 1'b1; in_valid4 = 1'b0; flush4 = 1'b0; out_ready4 = 1'b0;
      op4 = '0; a4 = '0; b4 = '0;
      #22;
      rst = 1'b0;
      rst4 = 1'b0;
      @(posedge clk);
      #1;
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_result", result, 64'd0);
      check_eq("rst_in_ready", 64'(in_ready), 64'd1);

      run_op("mul_7x-3", 6'd3, 64'd7, -64'sd3, -64'sd21, 65, 0);
      run_op("mulhu_max_x2", 6'd19, '1, 64'd2, 64'd1, 65, 0);
      run_op("div_-7_2", 6'd10, -64'sd7, 64'd2, -64'sd3, 65, 0);
      run_op("rem_-7_2", 6'd15, -64'sd7, 64'd2, -64'sd1, 65, 0);
      run_op("divu_100_7", 6'd13, 64'd100, 64'd7, 64'd14, 65, 0);
      run_op("remu_100_7", 6'd17, 64'd100, 64'd7, 64'd2, 65, 0);
      run_op("mulhsu_-1x2", 6'd20, '1, 64'd2, '1, 65, 0);
      run_op("mulh_neg", 6'd18, -64'sd5, 64'h4000_0000_0000_0000, -64'sd2, 65, 0);
      run_op("divu_5_0", 6'd13, 64'd5, 64'd0, '1, 1, 0);
      run_op("rem_5_0", 6'd15, 64'd5, 64'd0, 64'd5, 1, 0);
      run_op("div_ovf", 6'd10, MinInt, '1, MinInt, 1, 0);
      run_op("rem_ovf", 6'd15, MinInt, '1, 64'd0, 1, 0);
      run_op("unknown_op", 6'd7, 64'd9, 64'd9, 64'd0, 1, 0);
      run_op("backpressure", 6'd13, 64'd1000, 64'd9, 64'd111, 65, 10);

      for (int k = 0; k < 8; k++) begin
         o = ops[k];
         a = {$urandom, $urandom};
         b = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom} : 64'($urandom_range(1, 1000));
         if ($urandom_range(0, 1) == 0) b = -b;
         fast = (o == 6'd10 || o == 6'd13 || o == 6'd15 || o == 6'd17) &&
                ((b == '0) || ((o == 6'd10 || o == 6'd15) && a == MinInt && b == '1));
         run_op("random", o, a, b, ref_result(o, a, b), fast ? 1 : 65, 0);
      end

      // Flush part-way through a divide
      @(negedge clk);
      op = 6'd10; operand1 = 64'd1000; operand2 = 64'd7; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (29) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      #1;
      check_eq("flush_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      check_eq("flush_busy", 64'(busy), 64'd0);
      check_eq("flush_out_valid", 64'(out_valid), 64'd0);
      seen = 1'b0;
      repeat (70) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      check_eq("flush_no_result", 64'(seen), 64'd0);
      run_op("mul_3x4_after_flush", 6'd3, 64'd3, 64'd4, 64'd12, 65, 0);

      // Four bits per cycle
      @(negedge clk);
      check_eq("bpc4_in_ready", 64'(in_ready4), 64'd1);
      op4 = 6'd10; a4 = 64'd1000; b4 = 64'd9; in_valid4 = 1'b1;
      exp_q.push_back(64'd111);
      @(posedge clk);
      #1;
      in_valid4 = 1'b0;
      a4 = '0;
      b4 = '0;
      n = 0;
      while (!out_valid4 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_eq("bpc4_div_lat", 64'(n), 64'd17);
      check_eq("bpc4_div_res", result4, exp_q.pop_front());
      @(negedge clk);
      out_ready4 = 1'b1;
      @(posedge clk);
      #1;
      out_ready4 = 1'b0;

      @(negedge clk);
      op4 = 6'd13; a4 = 64'd12345; b4 = 64'd3; in_valid4 = 1'b1;
      @(posedge clk);
      #1;
      in_valid4 = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      check_eq("bpc4_busy_mid_run", 64'(busy4), 64'd1);
      rst4 = 1'b1;
      #1;
      check_eq("bpc4_rst_busy", 64'(busy4), 64'd0);
      check_eq("bpc4_rst_out_valid", 64'(out_valid4), 64'd0);
      check_eq("bpc4_rst_result", result4, 64'd0);
      @(negedge clk);
      rst4 = 1'b0;
      #1;
      check_eq("bpc4_rst_in_ready", 64'(in_ready4), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
